// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - op encodings for MULT/MULTU/DIV/DIVU
//   - FSM state type
//   - sign_fix(): conditional two's-complement negate on a wide vector.
//     Callers zero-extend into MD_MAXW bits and slice the low bits back out,
//     which is exact modulo 2^n. This bounds WIDTH to at most 64.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam int MD_MAXW = 130;

  function automatic logic [MD_MAXW-1:0] sign_fix(input logic [MD_MAXW-1:0] v,
                                                  input logic               neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational iteration of the multiply/divide datapath.
//   is_div   in  select restoring-divide step (1) or shift-add multiply step (0)
//   acc      in  2*WIDTH accumulator {upper, lower}
//   operand  in  multiplicand (multiply) or divisor (divide) magnitude
//   acc_next out accumulator after one step
// Multiply: lower half starts as the multiplier and is consumed LSB first;
// the product grows into the upper half as the pair shifts right.
// Divide: lower half starts as the dividend and is replaced by quotient bits
// from the right; the upper half holds the partial remainder.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   tmp;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Carry out of the add becomes the new MSB after the right shift.
  assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

  // Partial remainder shifted left with the next dividend bit; it can be
  // WIDTH+1 bits wide, but the difference always fits in WIDTH when ge.
  assign tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge   = tmp >= {1'b0, operand};
  assign diff = tmp[WIDTH-1:0] - operand;

  always_comb begin
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (ge) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else    acc_next = {tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
//   clk, rst_n        clock, async active-low reset
//   start, op         request and operation (sampled in IDLE only)
//   srcA, srcB        multiplicand/dividend, multiplier/divisor
//   flush             synchronous abort, highest priority
//   hi_we, lo_we,     MTHI/MTLO writes, honoured in IDLE only
//   wdata
//   busy, done        handshake; done is a one-cycle pulse with HI/LO valid
//   div_by_zero       set with done for a zero divisor, cleared on next start
//   hi, lo            HI/LO registers
// Build option MULDIV_FAST_MUL_EN: multiplies skip RUN and form the product
// directly in FIX; divide is unaffected.
//
// state   | meaning
// IDLE    | waiting for start, MTHI/MTLO writes accepted
// RUN     | one shift-add / shift-subtract step per cycle, WIDTH steps
// FIX     | apply result signs, write HI/LO, pulse done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  md_state_t          state;
  logic               is_div_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] full;
  logic [CW-1:0]      cnt;

  logic               sgn, sa, sb;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [MD_MAXW-1:0] t_prod, t_quot, t_rem;
  logic               unused_bits;

  assign sgn      = (op == MD_MULT) || (op == MD_DIV);
  assign sa       = sgn & srcA[WIDTH-1];
  assign sb       = sgn & srcB[WIDTH-1];
  // The most-negative value maps onto itself, which read unsigned is correct.
  assign in_mag_a = sa ? -srcA : srcA;
  assign in_mag_b = sb ? -srcB : srcB;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div_r),
    .acc      (acc),
    .operand  (mag_b),
    .acc_next (acc_step)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [WIDTH-1:0] mag_a;
  assign full = is_div_r ? acc : ((2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b));
`else
  assign full = acc;
`endif

  assign t_prod = sign_fix(MD_MAXW'(full), neg_q);
  assign t_quot = sign_fix(MD_MAXW'(full[WIDTH-1:0]), neg_q);
  assign t_rem  = sign_fix(MD_MAXW'(full[2*WIDTH-1:WIDTH]), neg_r);
  assign unused_bits = ^{t_prod[MD_MAXW-1:2*WIDTH], t_quot[MD_MAXW-1:WIDTH],
                         t_rem[MD_MAXW-1:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MD_IDLE;
      is_div_r    <= 1'b0;
      a_r         <= '0;
      mag_b       <= '0;
`ifdef MULDIV_FAST_MUL_EN
      mag_a       <= '0;
`endif
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          MD_IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              is_div_r    <= op[1];
              a_r         <= srcA;
              mag_b       <= in_mag_b;
`ifdef MULDIV_FAST_MUL_EN
              mag_a       <= in_mag_a;
`endif
              neg_q       <= sa ^ sb;
              neg_r       <= sa;
              acc         <= {{WIDTH{1'b0}}, in_mag_a};
              cnt         <= '0;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              state       <= MD_RUN;
`ifdef MULDIV_FAST_MUL_EN
              if (!op[1]) state <= MD_FIX;
`endif
            end
          end
          MD_RUN: begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
            if (cnt == CNT_LAST) state <= MD_FIX;
          end
          MD_FIX: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (is_div_r) begin
              if (mag_b == '0) begin
                hi          <= a_r;
                lo          <= '1;
                div_by_zero <= 1'b1;
              end else begin
                hi <= t_rem[WIDTH-1:0];
                lo <= t_quot[WIDTH-1:0];
              end
            end else begin
              hi <= t_prod[2*WIDTH-1:WIDTH];
              lo <= t_prod[WIDTH-1:0];
            end
          end
          default: begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0, srcB = '0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns 1ns after the edge that samples start.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  // Returns the index of the edge after which done is first seen.
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!done && k < 200);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] ehi,
                     input logic [31:0] elo, input logic edz);
    int k;
    issue(o, a, b);
    wait_done(k);
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, div_by_zero, edz);
    chk({tag, "_busy_in_done"}, busy, 0);
  endtask

  initial begin
    int k, ndone;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
        32'hFFFF_FFFE, 32'h0000_0001, 0);
    @(negedge clk);
    run("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    @(negedge clk);
    run("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    @(negedge clk);
    run("div_min", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
        32'h0, 32'h8000_0000, 0);
    @(negedge clk);
    run("divu_zero", MD_DIVU, 32'd5, 32'd0, DIV_LAT,
        32'd5, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    chk("dbz_hold", div_by_zero, 1);
    issue(MD_DIVU, 32'd9, 32'd4);
    chk("dbz_cleared", div_by_zero, 0);
    wait_done(k);
    chk("divu_9_4_lo", lo, 2);
    chk("divu_9_4_hi", hi, 1);
    run("div_zero_signed", MD_DIV, 32'hFFFF_FFF0, 32'd0, DIV_LAT,
        32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);

    // MTHI in idle
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_1234", hi, 32'h1234);

    // Flush mid-operation, with an MTHI attempt while busy
    @(negedge clk);
`ifdef MULDIV_FAST_MUL_EN
    issue(MD_DIVU, 32'd3, 32'd5);
`else
    issue(MD_MULTU, 32'd3, 32'd5);
`endif
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_busy_ignored", hi, 32'h1234);
    repeat (8) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, 32'h1234);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_hi_later", hi, 32'h1234);

    // Back-to-back: start in the done cycle
    run("b2b_first", MD_MULTU, 32'd2, 32'd3, MUL_LAT, 32'd0, 32'd6, 0);
    issue(MD_MULTU, 32'd4, 32'd5);
    wait_done(k);
    chk("b2b_second_lat", k, MUL_LAT);
    chk("b2b_second_lo", lo, 32'd20);

    // MTHI in idle again
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAA;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_aa", hi, 32'hAA);

    // Async reset mid-divide
    @(negedge clk);
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("divu_after_rst", MD_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
